bootram_loader: RTL and testbench

- Serial boot-image writer for the 2Kx8 single-port boot RAM.
- Takes a byte stream from the UART receiver (valid/data, no backpressure) and parses a framed image: sync byte, 16-bit length, payload, checksum.
- Writes the payload into the RAM from address 0, then reads it back to verify the checksum.
- Holds the CPU in reset until a verified image is present.

---
 rtl/bootram_loader.sv | 152 +++++++++++++++
 tb/tb_bootram_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bootram_loader.sv
// Boot-image loader: parses a framed byte stream (sync, 16-bit length, payload, checksum),
// writes the payload into the boot RAM, reads it back to verify, and releases cpu_hold on success.
module bootram_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         AW        = 11,
    parameter int         DEPTH     = 2048,
    parameter int         TIMEOUT   = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          ram_ce,
    output logic          ram_oce,
    output logic          ram_wre,
    output logic [AW-1:0] ram_ad,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_hold,
    output logic [3:0]    dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_L, S_LEN_H, S_DATA, S_CHK, S_VERIFY, S_FLUSH, S_DONE, S_ERROR
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [15:0]   r_len;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [7:0]    r_sum;
    logic [7:0]    r_vsum;
    logic [7:0]    r_chk;
    logic          r_rd_pend;
    logic [31:0]   r_tmo;

    logic [15:0]   w_len_new;
    logic          w_tmo_state;
    logic          w_tmo_hit;
    logic [7:0]    w_vsum_add;

    assign w_len_new   = {rx_data, r_len[7:0]};
    assign w_tmo_state = (r_state == S_LEN_L) || (r_state == S_LEN_H) ||
                         (r_state == S_DATA)  || (r_state == S_CHK);
    assign w_tmo_hit   = w_tmo_state && !rx_valid && (r_tmo == 32'(TIMEOUT));
    assign w_vsum_add  = r_vsum + ram_dout;
    assign dbg_state   = r_state;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // rx_valid is a one-cycle strobe with no backpressure; bytes that arrive
    // in VERIFY, FLUSH or DONE are simply dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (rx_valid && rx_data == SYNC_BYTE) w_next = S_LEN_L;
            S_LEN_L:  if (rx_valid) w_next = S_LEN_H;
                      else if (w_tmo_hit) w_next = S_ERROR;
            S_LEN_H:  if (rx_valid) begin
                          if (w_len_new == 16'd0 || w_len_new > 16'(DEPTH)) w_next = S_ERROR;
                          else w_next = S_DATA;
                      end else if (w_tmo_hit) w_next = S_ERROR;
            S_DATA:   if (rx_valid) begin
                          if (16'(r_wptr) == r_len - 16'd1) w_next = S_CHK;
                      end else if (w_tmo_hit) w_next = S_ERROR;
            S_CHK:    if (rx_valid) w_next = (rx_data == r_sum) ? S_VERIFY : S_ERROR;
                      else if (w_tmo_hit) w_next = S_ERROR;
            S_VERIFY: if (16'(r_rptr) == r_len - 16'd1) w_next = S_FLUSH;
            S_FLUSH:  w_next = (w_vsum_add == r_chk) ? S_DONE : S_ERROR;
            S_DONE:   w_next = S_DONE;
            S_ERROR:  if (rx_valid && rx_data == SYNC_BYTE) w_next = S_LEN_L;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_sum     <= '0;
            r_vsum    <= '0;
            r_chk     <= '0;
            r_rd_pend <= 1'b0;
            r_tmo     <= '0;
        end else begin
            if (!w_tmo_state || rx_valid) r_tmo <= '0;
            else                          r_tmo <= r_tmo + 32'd1;
            case (r_state)
                S_LEN_L: if (rx_valid) r_len[7:0] <= rx_data;
                S_LEN_H: if (rx_valid) begin
                    r_len[15:8] <= rx_data;
                    r_wptr      <= '0;
                    r_sum       <= '0;
                end
                S_DATA: if (rx_valid) begin
                    r_wptr <= r_wptr + 1'b1;
                    r_sum  <= r_sum + rx_data;
                end
                S_CHK: if (rx_valid) begin
                    r_chk     <= rx_data;
                    r_rptr    <= '0;
                    r_vsum    <= '0;
                    r_rd_pend <= 1'b0;
                end
                S_VERIFY: begin
                    // ram_dout carries the read issued in the previous cycle
                    r_rptr    <= r_rptr + 1'b1;
                    r_rd_pend <= 1'b1;
                    if (r_rd_pend) r_vsum <= w_vsum_add;
                end
                S_FLUSH: begin
                    r_vsum    <= w_vsum_add;
                    r_rd_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_oce  = 1'b1;
        ram_ce   = 1'b0;
        ram_wre  = 1'b0;
        ram_ad   = '0;
        ram_din  = '0;
        if (!reset) begin
            if (r_state == S_DATA && rx_valid) begin
                ram_ce  = 1'b1;
                ram_wre = 1'b1;
                ram_ad  = r_wptr;
                ram_din = rx_data;
            end else if (r_state == S_VERIFY) begin
                ram_ce = 1'b1;
                ram_ad = r_rptr;
            end
        end
        busy     = (r_state == S_LEN_L) || (r_state == S_LEN_H) || (r_state == S_DATA) ||
                   (r_state == S_CHK)   || (r_state == S_VERIFY) || (r_state == S_FLUSH);
        done     = (r_state == S_DONE);
        error    = (r_state == S_ERROR);
        cpu_hold = (r_state != S_DONE);
    end

endmodule

// File: tb/tb_bootram_loader.sv
// Bench for bootram_loader: RAM model, bus monitor, frame-level reference model and scenario tasks.
module tb_bootram_loader;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        ram_ce, ram_oce, ram_wre;
    logic [10:0] ram_ad;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        busy, done, error, cpu_hold;
    logic [3:0]  dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]  mem [0:2047];
    bit          corrupt_en = 1'b0;
    logic [18:0] wr_q[$];
    logic [10:0] rd_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  frame_q[$];

    bootram_loader #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
        .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy), .done(done),
        .error(error), .cpu_hold(cpu_hold), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Bypass-mode RAM model; optional fault turns 0x22 at address 1 into 0x23.
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) mem[ram_ad] <= (corrupt_en && ram_ad == 11'd1) ? ram_din + 8'd1 : ram_din;
            else         ram_dout <= mem[ram_ad];
        end
    end

    always @(negedge clk) begin
        if (ram_ce) begin
            if (ram_wre) wr_q.push_back({ram_ad, ram_din});
            else         rd_q.push_back(ram_ad);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        idle(2);
        reset = 1'b0;
        wr_q.delete(); rd_q.delete(); exp_q.delete(); frame_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap);
        foreach (frame_q[i]) begin
            send_byte(frame_q[i]);
            if (gap > 1) idle(gap - 1);
        end
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(done || error) && k < 6000) begin
            idle(1);
            k++;
        end
    endtask

    // Writes must be exactly the payload, in order, from address 0.
    function automatic bit writes_ok();
        if (wr_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (wr_q[i] !== {11'(i), exp_q[i]}) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit reads_ok(input int n);
        if (rd_q.size() != n) return 1'b0;
        foreach (rd_q[i]) if (rd_q[i] !== 11'(i)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({ram_ce, ram_wre, ram_oce, busy, done, error, cpu_hold} !== 7'b0010001) $display("FAIL reset_flags: got %b expected 0010001", {ram_ce, ram_wre, ram_oce, busy, done, error, cpu_hold}); else n_pass++;
        n_total++;
        if ({ram_ad, ram_din} !== 19'd0) $display("FAIL reset_bus: got %h expected 0", {ram_ad, ram_din}); else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66};
        exp_q   = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 6; i++) begin send_byte(frame_q[i]); idle(9); end
        send_byte(frame_q[6]);
        n_total++;
        if (busy !== 1'b1) $display("FAIL basic_busy_after_chk: got %b expected 1", busy); else n_pass++;
        idle(3);
        n_total++;
        if (done !== 1'b0) $display("FAIL basic_done_early: got %b expected 0", done); else n_pass++;
        idle(1);
        n_total++;
        if ({done, cpu_hold, busy, error} !== 4'b1000) $display("FAIL basic_done: got %b expected 1000", {done, cpu_hold, busy, error}); else n_pass++;
        n_total++;
        if (!writes_ok()) $display("FAIL basic_writes: got %0d writes expected %0d", wr_q.size(), exp_q.size()); else n_pass++;
        n_total++;
        if (!reads_ok(3)) $display("FAIL basic_reads: got %0d reads expected 3", rd_q.size()); else n_pass++;
        send_byte(8'hA5); idle(3);
        n_total++;
        if ({done, busy} !== 2'b10) $display("FAIL done_ignores_rx: got %b expected 10", {done, busy}); else n_pass++;
    endtask

    task automatic test_bad_chk();
        do_reset();
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h67};
        send_frame(10);
        n_total++;
        if ({error, cpu_hold, busy} !== 3'b110) $display("FAIL badchk_error: got %b expected 110", {error, cpu_hold, busy}); else n_pass++;
        idle(10);
        n_total++;
        if (rd_q.size() != 0) $display("FAIL badchk_reads: got %0d expected 0", rd_q.size()); else n_pass++;
        frame_q[6] = 8'h66;
        wr_q.delete(); rd_q.delete();
        send_frame(2);
        wait_end();
        n_total++;
        if ({done, error, cpu_hold} !== 3'b100) $display("FAIL badchk_recover: got %b expected 100", {done, error, cpu_hold}); else n_pass++;
    endtask

    task automatic test_bad_len();
        do_reset();
        frame_q = '{8'hA5, 8'h00, 8'h00};
        send_frame(1);
        n_total++;
        if ({error, busy} !== 2'b10) $display("FAIL len0_error: got %b expected 10", {error, busy}); else n_pass++;
        send_byte(8'hA5);
        n_total++;
        if ({error, busy} !== 2'b01) $display("FAIL error_restart: got %b expected 01", {error, busy}); else n_pass++;
        send_byte(8'h01); send_byte(8'h08);
        n_total++;
        if ({error, cpu_hold} !== 2'b11) $display("FAIL len801_error: got %b expected 11", {error, cpu_hold}); else n_pass++;
        send_byte(8'h55); idle(3);
        n_total++;
        if (wr_q.size() != 0 || error !== 1'b1) $display("FAIL badlen_writes: got %0d writes err=%b expected 0 writes err=1", wr_q.size(), error); else n_pass++;
    endtask

    task automatic test_full();
        bit mem_ok = 1'b1;
        do_reset();
        frame_q = '{8'hA5, 8'h00, 8'h08};
        for (int i = 0; i < 2048; i++) begin frame_q.push_back(8'(i)); exp_q.push_back(8'(i)); end
        frame_q.push_back(8'h00);
        send_frame(1);
        wait_end();
        n_total++;
        if ({done, error} !== 2'b10) $display("FAIL full_done: got %b expected 10", {done, error}); else n_pass++;
        n_total++;
        if (!writes_ok()) $display("FAIL full_writes: got %0d expected 2048", wr_q.size()); else n_pass++;
        n_total++;
        if (wr_q.size() == 0 || wr_q[wr_q.size()-1][18:8] !== 11'h7FF) $display("FAIL full_last_addr: got %0d writes expected last at 7ff", wr_q.size()); else n_pass++;
        n_total++;
        if (!reads_ok(2048)) $display("FAIL full_reads: got %0d expected 2048", rd_q.size()); else n_pass++;
        for (int i = 0; i < 2048; i++) if (mem[i] !== 8'(i)) mem_ok = 1'b0;
        n_total++;
        if (!mem_ok) $display("FAIL full_mem: got contents differ expected incrementing"); else n_pass++;
    endtask

    task automatic test_corrupt();
        do_reset();
        corrupt_en = 1'b1;
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66};
        send_frame(3);
        wait_end();
        corrupt_en = 1'b0;
        n_total++;
        if ({error, done, cpu_hold} !== 3'b101) $display("FAIL corrupt_error: got %b expected 101", {error, done, cpu_hold}); else n_pass++;
        n_total++;
        if (!reads_ok(3)) $display("FAIL corrupt_reads: got %0d expected 3", rd_q.size()); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        frame_q = '{8'hA5, 8'h05, 8'h00, 8'h01, 8'h02};
        send_frame(1);
        idle(TMO - 10);
        n_total++;
        if ({busy, error} !== 2'b10) $display("FAIL tmo_early: got %b expected 10", {busy, error}); else n_pass++;
        idle(20);
        n_total++;
        if ({busy, error, cpu_hold} !== 3'b011) $display("FAIL tmo_error: got %b expected 011", {busy, error, cpu_hold}); else n_pass++;
    endtask

    task automatic test_junk();
        do_reset();
        frame_q = '{8'h00, 8'hFF, 8'h5A, 8'h12};
        send_frame(2);
        n_total++;
        if ({busy, error} !== 2'b00) $display("FAIL junk_ignored: got %b expected 00", {busy, error}); else n_pass++;
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h7E, 8'h7E};
        send_frame(1);
        wait_end();
        n_total++;
        if (done !== 1'b1) $display("FAIL junk_then_frame: got %b expected 1", done); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        frame_q = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h02};
        send_frame(1);
        reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h03;
        #1;
        n_total++;
        if (ram_ce !== 1'b0) $display("FAIL reset_suppress_ce: got %b expected 0", ram_ce); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0; rx_valid = 1'b0;
        #1;
        n_total++;
        if ({ram_ce, ram_wre, busy, done, error, cpu_hold, ram_ad, ram_din} !== {6'b000001, 19'd0}) $display("FAIL reset_mid_outputs: got %b expected 000001", {ram_ce, ram_wre, busy, done, error, cpu_hold}); else n_pass++;
        n_total++;
        if (wr_q.size() != 2) $display("FAIL reset_mid_writes: got %0d expected 2", wr_q.size()); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int len, gap;
            logic [7:0] s, chk, b;
            bit good;
            do_reset();
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                frame_q.push_back(b);
            end
            len  = $urandom_range(1, 40);
            gap  = $urandom_range(1, 4);
            good = ($urandom_range(0, 3) != 0);
            frame_q.push_back(8'hA5);
            frame_q.push_back(8'(len));
            frame_q.push_back(8'(len >> 8));
            s = 8'h00;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                frame_q.push_back(b);
                exp_q.push_back(b);
                s = s + b;
            end
            chk = good ? s : s ^ 8'($urandom_range(1, 255));
            frame_q.push_back(chk);
            send_frame(gap);
            wait_end();
            idle(2);
            n_total++;
            if ({done, error} !== {good, !good}) $display("FAIL rand%0d_result: got %b expected %b", it, {done, error}, {good, !good}); else n_pass++;
            n_total++;
            if (!writes_ok()) $display("FAIL rand%0d_writes: got %0d expected %0d", it, wr_q.size(), exp_q.size()); else n_pass++;
            n_total++;
            if (!reads_ok(good ? len : 0)) $display("FAIL rand%0d_reads: got %0d expected %0d", it, rd_q.size(), good ? len : 0); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_chk();
        test_bad_len();
        test_full();
        test_corrupt();
        test_timeout();
        test_junk();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
